mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_timeout_ctr.sv | 42 ++++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the multicycle memory access unit.
// The ABORT encoding exists only when MEM_TIMEOUT_EN is defined.
package mem_access_unit_pkg;

    localparam int DEFAULT_N              = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10
`ifdef MEM_TIMEOUT_EN
        , ST_ABORT = 2'b11
`endif
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the access unit: request/write strobe/address/data out,
// read data and acknowledge back.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Busy-cycle watchdog for the access unit; built only with MEM_TIMEOUT_EN.
// expire_o flags the BUSY cycle in which the count would reach TIMEOUT_CYCLES.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (busy_i && !ack_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // An ack in the final cycle wins over the abort.
    assign expire_o = busy_i && !ack_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_access_unit.sv
// Memory access unit for a multicycle CPU: IDLE -> BUSY -> DONE handshake with
// registered outputs. MEM_TIMEOUT_EN adds a busy watchdog, ABORT state and sticky mem_err.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [N-1:0]      pc,
    input  logic [N-1:0]      alu_out,
    input  logic [N-1:0]      b_reg,
    output logic              mem_ready,
    output logic [N-1:0]      ir_out,
    output logic [N-1:0]      mdr_out,
    output logic              mem_err,
    mem_access_unit_if.master bus
);

    state_e       state_q, state_d;
    logic         req_q, req_d;
    logic         we_q, we_d;
    logic         ready_q, ready_d;
    logic         irw_q, irw_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] ir_q, ir_d;
    logic [N-1:0] mdr_q, mdr_d;
    logic         accept;
    logic         ack_seen;

    assign accept   = (state_q == ST_IDLE) && (MemRead || MemWrite);
    // Acks outside an active request are ignored, including stale ones after reset.
    assign ack_seen = req_q && bus.mem_ack;

`ifdef MEM_TIMEOUT_EN
    logic err_q, err_d;
    logic expire;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept),
        .busy_i   (state_q == ST_BUSY),
        .ack_i    (ack_seen),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign mem_err            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        ready_d = 1'b0;
        irw_d   = irw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
`ifdef MEM_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    // Write wins when both strobes are high; the read is dropped.
                    we_d    = MemWrite;
                    irw_d   = IRWrite && !MemWrite;
                    addr_d  = IorD ? alu_out : pc;
                    wdata_d = b_reg;
                end
            end
            ST_BUSY: begin
                if (ack_seen) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        mdr_d = bus.mem_rdata;
                        if (irw_q) begin
                            ir_d = bus.mem_rdata;
                        end
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (expire) begin
                    state_d = ST_ABORT;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end
`endif
            end
            default: begin
                // DONE (and ABORT) hold for exactly one cycle.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            irw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            irw_q   <= irw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign mem_ready     = ready_q;
    assign ir_out        = ir_q;
    assign mdr_out       = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver queues expected bus activity and
// responses, a memory responder and a ready monitor pop and compare them.
module tb_mem_access_unit;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] mdr;
        logic        err;
        int          lat;
        longint      t0;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        int          k;
        int          cycles;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
    logic [31:0] pc = '0, alu_out = '0, b_reg = '0;
    logic        mem_ready, mem_err;
    logic [31:0] ir_out, mdr_out;
    logic        mem_ack_r = 1'b0, stray_ack = 1'b0;
    logic [31:0] rdata_r = '0;

    resp_t exp_q[$];
    bus_t  bus_q[$];
    bit    bus_active = 1'b0;
    int    n_vec = 0, n_miss = 0;
    logic [31:0] m_ir = '0, m_mdr = '0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.N(32)) bus ();
    assign bus.mem_ack   = mem_ack_r | stray_ack;
    assign bus.mem_rdata = rdata_r;

    mem_access_unit #(.N(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .pc        (pc),
        .alu_out   (alu_out),
        .b_reg     (b_reg),
        .mem_ready (mem_ready),
        .ir_out    (ir_out),
        .mdr_out   (mdr_out),
        .mem_err   (mem_err),
        .bus       (bus)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Memory responder: checks captured bus values every request cycle, acks in cycle k.
    initial begin
        bus_t cur;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (!bus_active) begin
                    n_vec++;
                    if (bus_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL unexpected_req: got mem_req=1 required 0");
                    end else begin
                        cur        = bus_q.pop_front();
                        bus_active = 1'b1;
                        cyc        = 0;
                    end
                end
                if (bus_active) begin
                    cyc++;
                    chk("bus_addr", bus.mem_addr, cur.addr);
                    chk("bus_wdata", bus.mem_wdata, cur.wdata);
                    chk("bus_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
                    if (cur.k != 0 && cyc == cur.k) begin
                        mem_ack_r = 1'b1;
                        rdata_r   = cur.rdata;
                    end else begin
                        mem_ack_r = 1'b0;
                        rdata_r   = 32'hA5A5_0000 | 32'(cyc);
                    end
                end
            end else begin
                mem_ack_r = 1'b0;
                if (bus_active) begin
                    chk("req_cycles", 32'(cyc), 32'(cur.cycles));
                    bus_active = 1'b0;
                end
            end
        end
    end

    // Ready monitor: each mem_ready pulse pops one expected response.
    initial begin
        resp_t r;
        int    lat;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL spurious_ready: got mem_ready=1 required 0");
                end else begin
                    r   = exp_q.pop_front();
                    lat = int'(($time - r.t0) / 10);
                    $display("ready: ir=%h mdr=%h err=%b lat=%0d", ir_out, mdr_out, mem_err, lat);
                    chk("ir_out", ir_out, r.ir);
                    chk("mdr_out", mdr_out, r.mdr);
                    chk("mem_err", {31'b0, mem_err}, {31'b0, r.err});
                    chk("latency", 32'(lat), 32'(r.lat));
                end
            end
        end
    end

    // k = cycle of the ack within the request (1 = first), 0 = never ack.
    task automatic do_access(input logic rd, input logic wr, input logic iord, input logic irw,
                             input logic [31:0] pc_v, input logic [31:0] alu_v,
                             input logic [31:0] b_v, input logic [31:0] rdata_v, input int k);
        resp_t r;
        bus_t  b;
        bit    done;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        pc = pc_v; alu_out = alu_v; b_reg = b_v;
        b.addr = iord ? alu_v : pc_v;
        b.we = wr; b.wdata = b_v; b.rdata = rdata_v; b.k = k;
        b.cycles = (k != 0) ? k : TO;
        if (k == 0) begin
            m_err = 1'b1;
        end else if (!wr) begin
            m_mdr = rdata_v;
            if (irw) m_ir = rdata_v;
        end
        r.ir = m_ir; r.mdr = m_mdr; r.err = m_err; r.lat = b.cycles + 1; r.t0 = $time;
        bus_q.push_back(b);
        exp_q.push_back(r);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus_active) begin
                done = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!done) begin
            n_miss++;
            $display("FAIL access_done: got no completion required mem_ready within 100 cycles");
            exp_q.delete();
            bus_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_ready", {31'b0, mem_ready}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_ir", ir_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Read, zero wait, IR load
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h1111_2222, 32'h8C22_0004, 1);
        // Write, 3 waits: data held for 4 request cycles, registers untouched
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h7777_7777, 4);
        // Read into MDR only
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 32'h0, 32'h1234_5678, 2);
        // Read+write together becomes a single write; returned data must be dropped
        do_access(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1);

        // Reset in the 2nd busy cycle, then a stale ack after release
        @(negedge clk);
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h0000_0080; b_reg = 32'h0;
        bus_q.push_back('{addr: 32'h80, wdata: 32'h0, rdata: 32'h0, we: 1'b0, k: 0, cycles: 2});
        @(negedge clk);
        MemRead = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, bus.mem_req}, 32'h0);
        chk("arst_addr", bus.mem_addr, 32'h0);
        chk("arst_mdr", mdr_out, 32'h0);
        chk("arst_ir", ir_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_ir = '0; m_mdr = '0; m_err = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_ack_req", {31'b0, bus.mem_req}, 32'h0);
        chk("stale_ack_mdr", mdr_out, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Ack in the last allowed cycle completes normally
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 32'h0BAD_F00D, TO);
        // No ack: abort after TO request cycles, sticky error
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 32'h0, 32'h0, 32'h0, 0);
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0308, 32'h0, 32'h0, 32'h0000_0055, 1);
        chk("err_sticky", {31'b0, mem_err}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", {31'b0, mem_err}, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("resp_q_empty", 32'(exp_q.size()), 32'h0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
